// File: rtl/skeleton_pkg.sv
// ---- skeleton_pkg: shared types and width helpers for the event merger (rev 1.0) ----
`default_nettype none

package skeleton_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_TRANSFER = 1'b1
    } merge_state_t;

    // The metadata flag sits just above the payload.
    function automatic int meta_flag_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int word_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skeleton_fifo.sv
// ---- skeleton_fifo: first-word-fall-through FIFO with almost_full and sticky overflow (rev 1.0) ----
`default_nettype none

module skeleton_fifo
    import skeleton_pkg::*;
#(
    parameter int WIDTH        = 65,
    parameter int DEPTH        = 512,
    parameter int AFULL_MARGIN = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW+1)'(AFULL_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic             do_read;
    logic             do_write;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_read  = read_enable && !empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
    assign do_write = write_enable && (!full || do_read);

    assign read_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            almost_full <= ((DEPTH_C - count) <= MARGIN_C);
            if (write_enable && !do_write) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/skeleton_event_merger.sv
// ---- skeleton_event_merger: round-robin merge of framed word streams into one FIFO (rev 1.0) ----
`default_nettype none

module skeleton_event_merger #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int INPUT_DEPTH  = 512,
    parameter int OUTPUT_DEPTH = 1024,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [NUM_CHANNELS*(DATA_WIDTH+1)-1:0] input_data,
    input  logic [NUM_CHANNELS-1:0]                input_write_enable,
    output logic [NUM_CHANNELS-1:0]                input_almost_full,
    output logic [NUM_CHANNELS-1:0]                input_overflow,
    output logic [NUM_CHANNELS-1:0]                framing_error,
    output logic [DATA_WIDTH:0]                    output_data,
    output logic                                   output_empty,
    input  logic                                   output_read_enable,
    output logic                                   output_almost_full,
    output logic [31:0]                            events_merged
);

    import skeleton_pkg::*;

    localparam int W  = word_width(DATA_WIDTH);
    localparam int FB = meta_flag_bit(DATA_WIDTH);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [W-1:0]            in_head [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] in_empty;
    logic [NUM_CHANNELS-1:0] in_pop;
    logic [NUM_CHANNELS-1:0] in_full_unused;

    merge_state_t            state;
    logic [CW-1:0]           grant;
    logic [CW-1:0]           rr_ptr;
    logic [CW-1:0]           next_rr;
    logic                    first_word;
    logic                    scan_found;
    logic [CW-1:0]           scan_ch;
    logic                    move;
    logic                    discard;
    logic                    out_full;
    logic                    out_overflow_unused;

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_input_fifo
            skeleton_fifo #(
                .WIDTH        (W),
                .DEPTH        (INPUT_DEPTH),
                .AFULL_MARGIN (AFULL_MARGIN)
            ) u_fifo (
                .clock        (clock),
                .reset_n      (reset_n),
                .write_enable (input_write_enable[c]),
                .write_data   (input_data[c*W +: W]),
                .read_enable  (in_pop[c]),
                .read_data    (in_head[c]),
                .empty        (in_empty[c]),
                .full         (in_full_unused[c]),
                .almost_full  (input_almost_full[c]),
                .overflow     (input_overflow[c])
            );
        end
    endgenerate

    // Walk from the highest offset down so the channel closest to rr_ptr wins.
    always_comb begin
        scan_found = 1'b0;
        scan_ch    = rr_ptr;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            if (!in_empty[idx]) begin
                scan_found = 1'b1;
                scan_ch    = CW'(idx);
            end
        end
    end

    always_comb begin
        next_rr = grant + 1'b1;
        if (int'(grant) >= NUM_CHANNELS - 1) begin
            next_rr = '0;
        end
    end

    assign move    = (state == ST_TRANSFER) && !in_empty[grant] && !out_full;
    assign discard = (state == ST_IDLE) && scan_found && !in_head[scan_ch][FB];

    always_comb begin
        in_pop = '0;
        if (move) begin
            in_pop[grant] = 1'b1;
        end
        if (discard) begin
            in_pop[scan_ch] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            first_word    <= 1'b0;
            events_merged <= '0;
            framing_error <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_found) begin
                        if (in_head[scan_ch][FB]) begin
                            grant      <= scan_ch;
                            first_word <= 1'b1;
                            state      <= ST_TRANSFER;
                        end else begin
                            framing_error[scan_ch] <= 1'b1;
                        end
                    end
                end
                ST_TRANSFER: begin
                    if (move) begin
                        first_word <= 1'b0;
                        // Any flagged word after the header closes the event.
                        if (!first_word && in_head[grant][FB]) begin
                            events_merged <= events_merged + 32'd1;
                            rr_ptr        <= next_rr;
                            state         <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    skeleton_fifo #(
        .WIDTH        (W),
        .DEPTH        (OUTPUT_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_output_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (move),
        .write_data   (in_head[grant]),
        .read_enable  (output_read_enable),
        .read_data    (output_data),
        .empty        (output_empty),
        .full         (out_full),
        .almost_full  (output_almost_full),
        .overflow     (out_overflow_unused)
    );

endmodule

`default_nettype wire
